// File: rtl/whack_button_conditioner_if.sv
// Button-conditioner bundle.
// Carries the raw player buttons and game enable toward the conditioner, and the
// debounced levels and press events back to the game core.
//   btn_raw      raw asynchronous buttons, 1 = pressed
//   en           game active; 0 suppresses press events
//   btn_level    debounced button levels
//   press_onehot 1-cycle pulse per channel on debounced 0->1
//   press_valid  OR of press_onehot
//   press_idx    lowest set index of press_onehot; 0 when none
//   multi_press  more than one press_onehot bit set
// Modports: slave = conditioner side, master = game core / stimulus side.
interface whack_button_conditioner_if #(
    parameter int unsigned NUM_BTN = 8
);
    localparam int unsigned IdxW = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;

    logic [NUM_BTN-1:0] btn_raw;
    logic               en;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] press_onehot;
    logic               press_valid;
    logic [IdxW-1:0]    press_idx;
    logic               multi_press;

    modport slave (
        input  btn_raw,
        input  en,
        output btn_level,
        output press_onehot,
        output press_valid,
        output press_idx,
        output multi_press
    );

    modport master (
        output btn_raw,
        output en,
        input  btn_level,
        input  press_onehot,
        input  press_valid,
        input  press_idx,
        input  multi_press
    );
endinterface

// File: rtl/whack_button_conditioner.sv
// Input stage for the whack-a-mole game: synchronises, debounces and edge-detects
// the player buttons, emitting single-cycle press events gated by game enable.
// Ports:
//   clk    system clock (1 MHz nominal)
//   rst_n  synchronous active-low reset
//   bus    whack_button_conditioner_if.slave: btn_raw/en in; btn_level,
//          press_onehot, press_valid, press_idx, multi_press out
// All outputs derive from registered state only; btn_raw and en never reach an
// output combinationally.
module whack_button_conditioner #(
    parameter int unsigned NUM_BTN         = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 5000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input logic                      clk,
    input logic                      rst_n,
    whack_button_conditioner_if.slave bus
);
    localparam int unsigned IdxW = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] Last = CntW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] sync_q [SYNC_STAGES];
    logic [NUM_BTN-1:0] sync_d [SYNC_STAGES];
    logic [CntW-1:0]    cnt_q  [NUM_BTN];
    logic [CntW-1:0]    cnt_d  [NUM_BTN];
    logic [NUM_BTN-1:0] level_q, level_d;
    logic [NUM_BTN-1:0] press_q, press_d;
    logic [NUM_BTN-1:0] s;
    logic [IdxW-1:0]    idx;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d[0] = bus.btn_raw;
        for (int unsigned j = 1; j < SYNC_STAGES; j++) begin
            sync_d[j] = sync_q[j-1];
        end

        level_d = level_q;
        press_d = '0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            cnt_d[i] = '0;
            if (s[i] != level_q[i]) begin
                if (cnt_q[i] == Last) begin
                    level_d[i] = s[i];
                    // s differs from the old level, so s=1 means a debounced 0->1
                    press_d[i] = bus.en & s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '{default: '0};
            cnt_q   <= '{default: '0};
            level_q <= '0;
            press_q <= '0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    // Lowest set index wins: scan high to low so the last hit is the lowest.
    always_comb begin
        idx = '0;
        for (int i = int'(NUM_BTN) - 1; i >= 0; i--) begin
            if (press_q[i]) begin
                idx = IdxW'(i);
            end
        end
    end

    assign bus.btn_level    = level_q;
    assign bus.press_onehot = press_q;
    assign bus.press_valid  = |press_q;
    assign bus.press_idx    = idx;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign bus.multi_press  = |(press_q & (press_q - NUM_BTN'(1)));
endmodule

// File: tb/tb_whack_button_conditioner.sv
module tb_whack_button_conditioner;
    localparam int unsigned NB = 8;

    typedef struct {
        logic [7:0] onehot;
        logic [2:0] idx;
        logic       multi;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    whack_button_conditioner_if #(.NUM_BTN(NB)) bus ();

    whack_button_conditioner #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Press monitor: every cycle, a pulse must appear exactly when the scoreboard
    // head is due, and nowhere else.
    always @(negedge clk) begin
        logic exp_hit;
        exp_t e;
        exp_hit = (sb.size() > 0) && (sb[0].cyc == cyc);
        n_cmp++;
        assert (bus.press_valid === exp_hit)
        else begin
            n_err++;
            $error("FAIL press_valid@%0d: observed %b expected %b", cyc, bus.press_valid, exp_hit);
        end
        if (exp_hit) begin
            e = sb.pop_front();
            n_cmp++;
            assert (bus.press_onehot === e.onehot)
            else begin
                n_err++;
                $error("FAIL onehot@%0d: observed %h expected %h", cyc, bus.press_onehot, e.onehot);
            end
            n_cmp++;
            assert (bus.press_idx === e.idx)
            else begin
                n_err++;
                $error("FAIL idx@%0d: observed %0d expected %0d", cyc, bus.press_idx, e.idx);
            end
            n_cmp++;
            assert (bus.multi_press === e.multi)
            else begin
                n_err++;
                $error("FAIL multi@%0d: observed %b expected %b", cyc, bus.multi_press, e.multi);
            end
        end else begin
            n_cmp++;
            assert (bus.press_onehot === 8'h00)
            else begin
                n_err++;
                $error("FAIL idle_onehot@%0d: observed %h expected 00", cyc, bus.press_onehot);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // First sampling edge is the next posedge; pulse lands 5 edges after it.
    task automatic expect_press(input logic [7:0] oh, input logic [2:0] idx, input logic m);
        exp_t e;
        e.onehot = oh;
        e.idx    = idx;
        e.multi  = m;
        e.cyc    = cyc + 6;
        sb.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_level"}, bus.btn_level, 8'h00);
        chk({tag, "_onehot"}, bus.press_onehot, 8'h00);
        chk({tag, "_valid"}, {7'd0, bus.press_valid}, 8'h00);
        chk({tag, "_idx"}, {5'd0, bus.press_idx}, 8'h00);
        chk({tag, "_multi"}, {7'd0, bus.multi_press}, 8'h00);
    endtask

    initial begin
        // 1. reset with all buttons held
        rst_n       = 1'b0;
        bus.btn_raw = 8'hFF;
        bus.en      = 1'b0;
        step(2);
        chk_all_zero("reset");
        bus.btn_raw = 8'h00;
        rst_n       = 1'b1;
        step(8);
        chk("idle_level", bus.btn_level, 8'h00);

        // 2. single press on channel 3, held
        bus.en         = 1'b1;
        bus.btn_raw[3] = 1'b1;
        expect_press(8'h08, 3'd3, 1'b0);
        step(5);
        chk("b3_level_early", bus.btn_level, 8'h00);
        step(1);
        chk("b3_level", bus.btn_level, 8'h08);
        step(10);
        chk("b3_level_held", bus.btn_level, 8'h08);
        bus.btn_raw[3] = 1'b0;
        step(8);
        chk("b3_released", bus.btn_level, 8'h00);

        // 3. glitch of 3 cycles rejected, 4 cycles accepted
        bus.btn_raw[5] = 1'b1;
        step(3);
        bus.btn_raw[5] = 1'b0;
        step(10);
        chk("b5_glitch_level", bus.btn_level, 8'h00);
        bus.btn_raw[5] = 1'b1;
        expect_press(8'h20, 3'd5, 1'b0);
        step(4);
        bus.btn_raw[5] = 1'b0;
        step(2);
        chk("b5_level", bus.btn_level, 8'h20);
        step(8);
        chk("b5_released", bus.btn_level, 8'h00);

        // 4. simultaneous presses on 1 and 6
        bus.btn_raw = 8'h42;
        expect_press(8'h42, 3'd1, 1'b1);
        step(10);
        chk("multi_level", bus.btn_level, 8'h42);
        bus.btn_raw = 8'h00;
        step(10);
        chk("multi_released", bus.btn_level, 8'h00);

        // 5. press completes while disabled: dropped, not queued
        bus.en         = 1'b0;
        bus.btn_raw[2] = 1'b1;
        step(6);
        bus.en = 1'b1;
        chk("b2_dis_level", bus.btn_level, 8'h04);
        step(10);
        bus.btn_raw[2] = 1'b0;
        step(10);
        chk("b2_released", bus.btn_level, 8'h00);
        bus.btn_raw[2] = 1'b1;
        expect_press(8'h04, 3'd2, 1'b0);
        step(10);
        chk("b2_level", bus.btn_level, 8'h04);
        bus.btn_raw[2] = 1'b0;
        step(10);

        // 6. reset mid-debounce with button held
        bus.btn_raw[0] = 1'b1;
        step(3);
        rst_n = 1'b0;
        step(1);
        chk_all_zero("midreset");
        rst_n = 1'b1;
        expect_press(8'h01, 3'd0, 1'b0);
        step(5);
        chk("b0_level_early", bus.btn_level, 8'h00);
        step(1);
        chk("b0_level", bus.btn_level, 8'h01);
        step(6);

        n_cmp++;
        assert (sb.size() === 0)
        else begin
            n_err++;
            $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
